// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU sharing sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic port_id_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin select; last_grant only moves when the grant is consumed.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic       gnt_valid,
  output port_id_t   gnt_id
);

  port_id_t last_q;
  port_id_t last_d;

  // Grant selection and last_grant next value
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    last_d    = last_q;
    if (req[0] && req[1]) begin
      gnt_id = other_port(last_q);
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
    if (update_en) begin
      last_d = gnt_id;
    end else begin
      last_d = last_q;
    end
  end

  // last_grant register; resets to port 1 so port 0 wins first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, one op in flight.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  state_e           state_q, state_d;
  port_id_t         owner_q, owner_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             gnt_valid;
  port_id_t         gnt_id;
  logic             arb_en;
  logic             rsp_take;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .update_en (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next-state, issue/result capture and request-side handshake
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    arb_en     = 1'b0;
    rsp_take   = (owner_q == 1'b1) ? rsp1_ready : rsp0_ready;
    case (state_q)
      ST_IDLE: begin
        // The arbiter only grants a valid port, so ready implies handshake
        if (gnt_valid) begin
          req0_ready = (gnt_id == 1'b0);
          req1_ready = (gnt_id == 1'b1);
          arb_en     = 1'b1;
          owner_d    = gnt_id;
          op_d       = (gnt_id == 1'b1) ? req1_op : req0_op;
          a_d        = (gnt_id == 1'b1) ? req1_a  : req0_a;
          b_d        = (gnt_id == 1'b1) ? req1_b  : req0_b;
          state_d    = ST_EXEC;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, owner, issue and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      op_q     <= 4'b0000;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // ALU inputs come straight from the issue register, so they hold between ops
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign busy        = (state_q != ST_IDLE);
  assign rsp0_valid  = (state_q == ST_RESP) && (owner_q == 1'b0);
  assign rsp1_valid  = (state_q == ST_RESP) && (owner_q == 1'b1);
  assign rsp0_result = (owner_q == 1'b0) ? result_q : {WIDTH{1'b0}};
  assign rsp1_result = (owner_q == 1'b1) ? result_q : {WIDTH{1'b0}};

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an external ALU model and a response scoreboard.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             busy;

  typedef struct {
    logic             port;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] ops_tbl [4] = '{OP_ADD, OP_SUB, OP_XOR, OP_SLL};
  int   idx0, idx1, grants, cyc;
  logic g0, g1;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return WIDTH'($signed(a) >>> b[4:0]);
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return ~(a ^ {b[27:0], op});
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) sb.push_back('{1'b0, alu_model(req0_op, req0_a, req0_b)});
      if (req1_valid && req1_ready) sb.push_back('{1'b1, alu_model(req1_op, req1_a, req1_b)});
      if (req0_ready && !req0_valid) chk1("ready0_without_valid", req0_ready, 1'b0);
      if (req1_ready && !req1_valid) chk1("ready1_without_valid", req1_ready, 1'b0);
      if (rsp0_valid || rsp1_valid) begin
        chk1("rsp_exclusive", rsp0_valid && rsp1_valid, 1'b0);
        chk1("rsp_expected", sb.size() > 0, 1'b1);
      end
      if (sb.size() > 0 && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
        chk1("sb_port", rsp1_valid, sb[0].port);
        chk("sb_result", rsp1_valid ? rsp1_result : rsp0_result, sb[0].res);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive0(1'b0, 4'b0000, 32'd0, 32'd0);
    drive1(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // Port 0 ADD 5+7, response ready already high
    rsp0_ready = 1'b1;
    drive0(1'b1, OP_ADD, 32'd5, 32'd7);
    #1 chk1("t1_req0_ready", req0_ready, 1'b1);
    next_cycle();
    drive0(1'b0, OP_ADD, 32'd5, 32'd7);
    chk1("t1_busy_exec", busy, 1'b1);
    chk("t1_alu_a", alu_a, 32'd5);
    chk1("t1_rsp0_valid_exec", rsp0_valid, 1'b0);
    next_cycle();
    chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_result", rsp0_result, 32'd12);
    chk1("t1_rsp1_valid", rsp1_valid, 1'b0);
    next_cycle();
    chk1("t1_idle_busy", busy, 1'b0);
    chk1("t1_idle_rsp0", rsp0_valid, 1'b0);

    // Port 1 SUB 10-3, with a non-owner ready also high
    rsp1_ready = 1'b1;
    drive1(1'b1, OP_SUB, 32'd10, 32'd3);
    #1 chk1("t2_req1_ready", req1_ready, 1'b1);
    next_cycle();
    drive1(1'b0, OP_SUB, 32'd10, 32'd3);
    chk("t2_alu_op", 32'(alu_op), 32'(OP_SUB));
    chk("t2_alu_a", alu_a, 32'd10);
    chk("t2_alu_b", alu_b, 32'd3);
    next_cycle();
    chk1("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk1("t2_rsp0_valid", rsp0_valid, 1'b0);
    chk("t2_rsp1_result", rsp1_result, 32'd7);
    next_cycle();

    // Fresh reset, then both ports stream four ops each
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    idx0 = 0; idx1 = 0; grants = 0; cyc = 0;
    while ((idx0 < 4 || idx1 < 4) && cyc < 200) begin
      drive0(idx0 < 4, ops_tbl[idx0 % 4], 32'(100 * idx0 + 3), 32'(idx0 + 1));
      drive1(idx1 < 4, ops_tbl[idx1 % 4], 32'(100 * idx1 + 1003), 32'(idx1 + 2));
      #1;
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 || g1) begin
        chk1("t3_rr_order", g1, grants[0]);
        grants++;
      end
      next_cycle();
      if (g0) idx0++;
      if (g1) idx1++;
      cyc++;
    end
    chk("t3_grant_count", 32'(grants), 32'd8);
    drive0(1'b0, OP_AND, 32'd0, 32'd0);
    drive1(1'b0, OP_AND, 32'd0, 32'd0);
    repeat (3) next_cycle();
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // Response backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    drive0(1'b1, OP_ADD, 32'd1, 32'd1);
    #1 chk1("t4_req0_ready", req0_ready, 1'b1);
    next_cycle();
    drive0(1'b0, OP_ADD, 32'd1, 32'd1);
    drive1(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    #1 chk1("t4_req1_ready_exec", req1_ready, 1'b0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      chk1("t4_rsp0_held", rsp0_valid, 1'b1);
      chk("t4_result_held", rsp0_result, 32'd2);
      chk1("t4_busy", busy, 1'b1);
      chk1("t4_req1_blocked", req1_ready, 1'b0);
      next_cycle();
    end
    rsp0_ready = 1'b1;
    #1 chk1("t4_rsp0_release", rsp0_valid, 1'b1);
    next_cycle();
    chk1("t4_idle_rsp0", rsp0_valid, 1'b0);
    chk1("t4_req1_pending", req1_ready, 1'b1);
    next_cycle();
    drive1(1'b0, OP_AND, 32'd0, 32'd0);
    next_cycle();
    chk1("t4_rsp1_valid", rsp1_valid, 1'b1);
    chk("t4_rsp1_result", rsp1_result, 32'h0000_F000);
    next_cycle();

    // Reset asserted during EXEC of a port 1 op
    drive1(1'b1, OP_XOR, 32'h0000_1234, 32'h0000_00FF);
    #1 chk1("t5_req1_ready", req1_ready, 1'b1);
    next_cycle();
    drive1(1'b0, OP_XOR, 32'd0, 32'd0);
    chk("t5_alu_op_exec", 32'(alu_op), 32'(OP_XOR));
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_alu_op", 32'(alu_op), 32'd0);
    chk("t5_rst_alu_a", alu_a, 32'd0);
    chk("t5_rst_alu_b", alu_b, 32'd0);
    chk1("t5_rst_rsp1", rsp1_valid, 1'b0);
    chk("t5_rst_rsp1_result", rsp1_result, 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      chk1("t5_no_rsp1", rsp1_valid, 1'b0);
      next_cycle();
    end
    drive0(1'b1, OP_SLT, 32'hFFFF_FFFB, 32'd3);
    drive1(1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    #1;
    chk1("t5_contend_req0", req0_ready, 1'b1);
    chk1("t5_contend_req1", req1_ready, 1'b0);
    next_cycle();
    drive0(1'b0, OP_SLT, 32'd0, 32'd0);
    next_cycle();
    chk("t5_slt_result", rsp0_result, 32'd1);
    next_cycle();
    #1 chk1("t5_req1_next", req1_ready, 1'b1);
    next_cycle();
    drive1(1'b0, OP_SRA, 32'd0, 32'd0);
    next_cycle();
    chk("t5_sra_result", rsp1_result, 32'hF800_0000);
    next_cycle();

    // Undefined op code passes through untouched
    drive0(1'b1, 4'b1110, 32'hCAFE_0000, 32'h0000_1234);
    next_cycle();
    drive0(1'b0, 4'b0000, 32'd0, 32'd0);
    chk("t6_alu_op", 32'(alu_op), 32'(4'b1110));
    next_cycle();
    chk("t6_rsp0_result", rsp0_result, alu_model(4'b1110, 32'hCAFE_0000, 32'h0000_1234));
    next_cycle();
    next_cycle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
